pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Drives enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, EX-stage redirects (taken branch/jump), instruction- and data-memory wait states, and halt.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- CNT_W, 32, width of the o_stall_cycles and o_flush_count counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_id_rs1_addr  in  5  rs1 of the instruction in ID
- i_id_rs2_addr  in  5  rs2 of the instruction in ID
- i_id_uses_rs1  in  1  ID instruction reads rs1
- i_id_uses_rs2  in  1  ID instruction reads rs2
- i_ex_rd_addr  in  5  rd of the instruction in EX
- i_ex_mem_read  in  1  EX instruction is a load
- i_ex_redirect  in  1  EX resolved a taken branch or jump
- i_imem_busy  in  1  instruction fetch not yet returned
- i_dmem_busy  in  1  data access not yet complete
- i_halt  in  1  WB instruction is ebreak/ecall
- o_pc_en  out  1  PC register load enable
- o_ifid_en  out  1  IF/ID load enable
- o_ifid_flush  out  1  load NOP into IF/ID (only effective when o_ifid_en=1)
- o_idex_en  out  1  ID/EX load enable
- o_idex_flush  out  1  load bubble into ID/EX (control signals 0, instruction 0x00000013)
- o_exmem_en  out  1  EX/MEM load enable
- o_memwb_en  out  1  MEM/WB load enable
- o_halted  out  1  core halted
- o_stall_cycles  out  CNT_W  saturating count of stall cycles
- o_flush_count  out  CNT_W  saturating count of redirects

Behaviour:
- FSM states: RUN, KILL, HALTED. Reset forces RUN.
- Reset values: o_halted=0; both counters 0. Enable and flush outputs are combinational from state and inputs.
- Load-use hazard (luh) is asserted when all of the following hold:
  - i_ex_mem_read=1
  - i_ex_rd_addr != 0
  - (i_id_uses_rs1 and rs1==rd) or (i_id_uses_rs2 and rs2==rd)
- RUN evaluates conditions in this priority order; the first match applies:
  1. i_halt:
     - All enables 0, no flush.
     - Next state HALTED.
  2. i_dmem_busy:
     - All enables 0, no flush.
     - Stall counter +1. Overrides a simultaneous redirect, which is held by the frozen EX stage and taken later.
  3. i_ex_redirect:
     - All enables 1, o_ifid_flush=1, o_idex_flush=1.
     - Flush counter +1.
     - If i_imem_busy=1, next state KILL.
  4. luh:
     - o_pc_en=0, o_ifid_en=0, o_idex_en=1, o_idex_flush=1; EX/MEM and MEM/WB enabled.
     - Stall counter +1.
     - Single bubble; the hazard clears the next cycle by construction.
  5. i_imem_busy:
     - o_pc_en=0, o_ifid_en=1, o_ifid_flush=1; ID/EX, EX/MEM and MEM/WB enabled.
     - Stall counter +1.
  6. Otherwise all enables 1, no flush.
- KILL discards the in-flight wrong-path fetch:
  - i_halt: same as RUN rule 1.
  - Else if i_dmem_busy: freeze all, stay in KILL, stall counter +1.
  - Else: o_pc_en=0, o_ifid_en=1, o_ifid_flush=1; downstream stages enabled; stall counter +1.
  - When i_imem_busy=0 in that cycle, the returned word is discarded and the next state is RUN.
  - i_ex_redirect and luh cannot occur in KILL because EX holds a bubble. They are ignored, and an assertion flags them.
- HALTED:
  - All enables 0, o_halted=1, counters frozen.
  - Exited only by reset.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-operation (any state) clears the state and counters immediately; RUN behaviour resumes on the first clock edge after deassertion.
- Latency: zero-cycle combinational control; registered state takes effect the next cycle.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state enum (RUN=2'd0, KILL=2'd1, HALTED=2'd2)
  - NOP constant 32'h00000013
  - CNT_W default
- Sub-module hazard_detect: purely combinational luh computation, reusable by the forwarding unit.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 -> exactly one cycle with o_pc_en=0, o_ifid_en=0, o_idex_flush=1; stall_cycles=1. Repeat with rd=x0 -> no stall.
- Redirect, imem idle: i_ex_redirect=1 -> same cycle o_ifid_flush=1, o_idex_flush=1, o_pc_en=1; flush_count=1; state stays RUN.
- Redirect with i_imem_busy high 3 cycles: state KILL for 3 cycles, o_ifid_flush=1 and o_pc_en=0 throughout; RUN on the cycle after busy drops; stall_cycles=3.
- i_dmem_busy and i_ex_redirect together for 2 cycles -> all enables 0, no flush; redirect acted on in cycle 3; stall_cycles=2, flush_count=1.
- i_halt=1 -> all enables 0; o_halted=1 next cycle and held for 10 cycles with counters frozen.
- Force o_stall_cycles to all-ones with CNT_W=4, then one more stall -> value stays 4'hF. Assert i_rst_n=0 asynchronously while in KILL -> state RUN, counters 0, without a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      KILL   = 2'd1,
      HALTED = 2'd2
   } state_e;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam int unsigned CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-control outputs between the datapath and the controller.
interface pipeline_ctrl_if #(
   parameter int unsigned CNT_W = pipeline_ctrl_pkg::CNT_W_DEF
);
   logic [4:0]       i_id_rs1_addr;
   logic [4:0]       i_id_rs2_addr;
   logic             i_id_uses_rs1;
   logic             i_id_uses_rs2;
   logic [4:0]       i_ex_rd_addr;
   logic             i_ex_mem_read;
   logic             i_ex_redirect;
   logic             i_imem_busy;
   logic             i_dmem_busy;
   logic             i_halt;
   logic             o_pc_en;
   logic             o_ifid_en;
   logic             o_ifid_flush;
   logic             o_idex_en;
   logic             o_idex_flush;
   logic             o_exmem_en;
   logic             o_memwb_en;
   logic             o_halted;
   logic [CNT_W-1:0] o_stall_cycles;
   logic [CNT_W-1:0] o_flush_count;

   modport master (
      output i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
             i_ex_rd_addr, i_ex_mem_read, i_ex_redirect, i_imem_busy,
             i_dmem_busy, i_halt,
      input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
             o_exmem_en, o_memwb_en, o_halted, o_stall_cycles, o_flush_count
   );

   modport slave (
      input  i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
             i_ex_rd_addr, i_ex_mem_read, i_ex_redirect, i_imem_busy,
             i_dmem_busy, i_halt,
      output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
             o_exmem_en, o_memwb_en, o_halted, o_stall_cycles, o_flush_count
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX whose rd feeds a source of the ID instruction.
module pipeline_ctrl_hazard_detect (
   input  logic [4:0] i_id_rs1_addr,
   input  logic [4:0] i_id_rs2_addr,
   input  logic       i_id_uses_rs1,
   input  logic       i_id_uses_rs2,
   input  logic [4:0] i_ex_rd_addr,
   input  logic       i_ex_mem_read,
   output logic       o_luh
);
   always_comb begin
      o_luh = i_ex_mem_read && (i_ex_rd_addr != 5'd0) &&
              ((i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr)) ||
               (i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr)));
   end
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: combinational stage controls,
// registered RUN/KILL/HALTED state and saturating stall/redirect counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   pipeline_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             luh;
   logic             stall_inc, flush_inc;
   logic             pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
   logic             exmem_en_c, memwb_en_c;

   pipeline_ctrl_hazard_detect u_hazard (
      .i_id_rs1_addr (bus.i_id_rs1_addr),
      .i_id_rs2_addr (bus.i_id_rs2_addr),
      .i_id_uses_rs1 (bus.i_id_uses_rs1),
      .i_id_uses_rs2 (bus.i_id_uses_rs2),
      .i_ex_rd_addr  (bus.i_ex_rd_addr),
      .i_ex_mem_read (bus.i_ex_mem_read),
      .o_luh         (luh)
   );

   // Next state and stage controls; defaults freeze everything.
   always_comb begin
      state_d      = state_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      ifid_flush_c = 1'b0;
      idex_en_c    = 1'b0;
      idex_flush_c = 1'b0;
      exmem_en_c   = 1'b0;
      memwb_en_c   = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.i_halt) begin
               state_d = HALTED;
            end else if (bus.i_dmem_busy) begin
               // The frozen EX stage keeps any pending redirect for later.
               stall_inc = 1'b1;
            end else if (bus.i_ex_redirect) begin
               {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b11111;
               ifid_flush_c = 1'b1;
               idex_flush_c = 1'b1;
               flush_inc    = 1'b1;
               if (bus.i_imem_busy) state_d = KILL;
            end else if (luh) begin
               {idex_en_c, exmem_en_c, memwb_en_c} = 3'b111;
               idex_flush_c = 1'b1;
               stall_inc    = 1'b1;
            end else if (bus.i_imem_busy) begin
               {ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 4'b1111;
               ifid_flush_c = 1'b1;
               stall_inc    = 1'b1;
            end else begin
               {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 5'b11111;
            end
         end
         KILL: begin
            if (bus.i_halt) begin
               state_d = HALTED;
            end else if (bus.i_dmem_busy) begin
               stall_inc = 1'b1;
            end else begin
               // Wrong-path fetch: the word arriving this cycle is dropped as a NOP.
               {ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = 4'b1111;
               ifid_flush_c = 1'b1;
               stall_inc    = 1'b1;
               if (!bus.i_imem_busy) state_d = RUN;
            end
         end
         HALTED: state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      halted_d = (state_d == HALTED);
      stall_d  = stall_q;
      flush_d  = flush_q;
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
         stall_q  <= '0;
         flush_q  <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
         stall_q  <= stall_d;
         flush_q  <= flush_d;
      end
   end

   assign bus.o_pc_en        = pc_en_c;
   assign bus.o_ifid_en      = ifid_en_c;
   assign bus.o_ifid_flush   = ifid_flush_c;
   assign bus.o_idex_en      = idex_en_c;
   assign bus.o_idex_flush   = idex_flush_c;
   assign bus.o_exmem_en     = exmem_en_c;
   assign bus.o_memwb_en     = memwb_en_c;
   assign bus.o_halted       = halted_q;
   assign bus.o_stall_cycles = stall_q;
   assign bus.o_flush_count  = flush_q;

   // EX holds a bubble while killing a fetch, so neither a redirect nor a load-use can appear.
   a_kill_quiet : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (state_q == KILL) |-> !(bus.i_ex_redirect || luh));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: hand-derived expectations queued per cycle.
module tb_pipeline_ctrl;

   localparam int unsigned CW = 4;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
   localparam logic [6:0] C_RUN = 7'b1101011;
   localparam logic [6:0] C_FRZ = 7'b0000000;
   localparam logic [6:0] C_RDR = 7'b1111111;
   localparam logic [6:0] C_LUH = 7'b0001111;
   localparam logic [6:0] C_IMB = 7'b0111011;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       u1, u2, mr, redir, imb, dmb, halt;
   } stim_t;

   typedef struct {
      string      tag;
      logic [6:0] ctl;
      logic       h;
      int         st;
      int         fl;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   pipeline_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_ctrl #(.CNT_W(CW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u1, input logic u2,
                                input logic mr, input logic redir, input logic imb,
                                input logic dmb, input logic halt);
      stim_t s;
      s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.u1 = u1; s.u2 = u2; s.mr = mr;
      s.redir = redir; s.imb = imb; s.dmb = dmb; s.halt = halt;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      bus.i_id_rs1_addr = s.rs1;
      bus.i_id_rs2_addr = s.rs2;
      bus.i_ex_rd_addr  = s.rd;
      bus.i_id_uses_rs1 = s.u1;
      bus.i_id_uses_rs2 = s.u2;
      bus.i_ex_mem_read = s.mr;
      bus.i_ex_redirect = s.redir;
      bus.i_imem_busy   = s.imb;
      bus.i_dmem_busy   = s.dmb;
      bus.i_halt        = s.halt;
   endtask

   task automatic sb_push(input string tag, input logic [6:0] ctl, input logic h,
                          input int st, input int fl);
      exp_t e;
      e.tag = tag; e.ctl = ctl; e.h = h; e.st = st; e.fl = fl;
      sb.push_back(e);
   endtask

   task automatic sb_compare();
      exp_t e;
      logic [6:0] ctl;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         return;
      end
      e   = sb.pop_front();
      ctl = {bus.o_pc_en, bus.o_ifid_en, bus.o_ifid_flush, bus.o_idex_en,
             bus.o_idex_flush, bus.o_exmem_en, bus.o_memwb_en};
      check({e.tag, ".ctl"},    32'(ctl),                e.ctl);
      check({e.tag, ".halted"}, 32'(bus.o_halted),       32'(e.h));
      check({e.tag, ".stall"},  32'(bus.o_stall_cycles), 32'(e.st));
      check({e.tag, ".flush"},  32'(bus.o_flush_count),  32'(e.fl));
   endtask

   // Drive one cycle's inputs on the falling edge and check before the next rising edge.
   task automatic cyc(input string tag, input stim_t s, input logic [6:0] ctl,
                      input logic h, input int st, input int fl);
      @(negedge clk);
      apply(s);
      sb_push(tag, ctl, h, st, fl);
      #2;
      sb_compare();
   endtask

   initial begin
      stim_t idle, lu, lu0, rdr, rdr_imb, imb, dmb_rdr, dmb_imb, halt;
      idle    = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
      lu      = mk(5'd5, 5'd1, 5'd5, 1, 1, 1, 0, 0, 0, 0);
      lu0     = mk(5'd0, 5'd1, 5'd0, 1, 1, 1, 0, 0, 0, 0);
      rdr     = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0);
      rdr_imb = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0);
      imb     = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0);
      dmb_rdr = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, 0);
      dmb_imb = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0);
      halt    = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1);

      rst_n = 1'b0;
      apply(idle);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      cyc("rst",    idle, C_RUN, 0, 0, 0);
      cyc("lu",     lu,   C_LUH, 0, 0, 0);
      cyc("lu_end", idle, C_RUN, 0, 1, 0);
      cyc("lu_x0",  lu0,  C_RUN, 0, 1, 0);
      cyc("idle1",  idle, C_RUN, 0, 1, 0);

      cyc("rdr",    rdr,  C_RDR, 0, 1, 0);
      cyc("rdr_nx", idle, C_RUN, 0, 1, 1);

      cyc("kill0",  rdr_imb, C_RDR, 0, 1, 1);
      cyc("kill1",  imb,     C_IMB, 0, 1, 2);
      cyc("kill2",  imb,     C_IMB, 0, 2, 2);
      cyc("kill3",  idle,    C_IMB, 0, 3, 2);
      cyc("kill_x", idle,    C_RUN, 0, 4, 2);

      cyc("dr1",    dmb_rdr, C_FRZ, 0, 4, 2);
      cyc("dr2",    dmb_rdr, C_FRZ, 0, 5, 2);
      cyc("dr3",    rdr,     C_RDR, 0, 6, 2);
      cyc("dr_nx",  idle,    C_RUN, 0, 6, 3);

      cyc("kd1",    rdr_imb, C_RDR, 0, 6, 3);
      cyc("kd2",    dmb_imb, C_FRZ, 0, 6, 4);
      cyc("kd3",    idle,    C_IMB, 0, 7, 4);
      cyc("kd_nx",  idle,    C_RUN, 0, 8, 4);

      // Enter KILL, then pull reset between clock edges.
      cyc("ar1",    rdr_imb, C_RDR, 0, 8, 4);
      @(negedge clk);
      apply(idle);
      sb_push("kill_pre", C_IMB, 0, 8, 5);
      #1;
      sb_compare();
      rst_n = 1'b0;
      sb_push("async_rst", C_RUN, 0, 0, 0);
      #1;
      sb_compare();
      @(negedge clk);
      rst_n = 1'b1;
      cyc("post_rst", idle, C_RUN, 0, 0, 0);

      for (int i = 0; i < 17; i++) cyc("sat", imb, C_IMB, 0, (i > 15) ? 15 : i, 0);
      cyc("sat_end", idle, C_RUN, 0, 15, 0);

      cyc("halt", halt, C_FRZ, 0, 15, 0);
      for (int i = 0; i < 10; i++)
         cyc("halted", (i % 3 == 0) ? lu : ((i % 3 == 1) ? rdr_imb : dmb_imb),
             C_FRZ, 1, 15, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
